// File: rtl/qdec_pkg.sv
// Shared types, quadrature constants and the Gray-code transition decoder for qdec_step_gen.
// QDEC_FILTER_EN (optional define) enables the per-input stability filter.
package qdec_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } qdec_state_t;

  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q01 = 2'b01;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q10 = 2'b10;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

`ifdef QDEC_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif

  typedef struct packed {
    logic legal_step;
    logic dir;
    logic illegal;
  } qdec_dec_t;

  // prev/cur are {a,b}; dir is only meaningful when legal_step is set.
  function automatic qdec_dec_t qdec_decode(input logic [1:0] prev, input logic [1:0] cur);
    qdec_dec_t res;
    res.legal_step = 1'b0;
    res.dir        = DIR_UP;
    res.illegal    = 1'b0;
    case ({prev, cur})
      {Q00, Q01}, {Q01, Q11}, {Q11, Q10}, {Q10, Q00}: begin
        res.legal_step = 1'b1;
        res.dir        = DIR_UP;
      end
      {Q00, Q10}, {Q10, Q11}, {Q11, Q01}, {Q01, Q00}: begin
        res.legal_step = 1'b1;
        res.dir        = DIR_DN;
      end
      {Q00, Q11}, {Q11, Q00}, {Q01, Q10}, {Q10, Q01}: begin
        res.illegal = 1'b1;
      end
      default: begin
        res.legal_step = 1'b0;
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/qdec_sync.sv
// Two-FF synchroniser for one asynchronous encoder input, followed by a
// stability filter when QDEC_FILTER_EN is defined.
module qdec_sync
  import qdec_pkg::*;
`ifdef QDEC_FILTER_EN
  #(
    parameter int FILTER_LEN = 4
  )
`endif
  (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic d_sync
  );

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d_async;
      sync_reg <= meta_reg;
    end
  end

`ifdef QDEC_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN);

  logic [CW-1:0] run_reg;
  logic          filt_reg;

  // run_reg counts consecutive clocks where the synced value disagrees with the
  // filtered one; any agreeing sample restarts the run.
  always_ff @(posedge clk) begin
    if (!rst) begin
      run_reg  <= '0;
      filt_reg <= 1'b0;
    end else if (sync_reg == filt_reg) begin
      run_reg <= '0;
    end else if (run_reg == CW'(FILTER_LEN - 1)) begin
      filt_reg <= sync_reg;
      run_reg  <= '0;
    end else begin
      run_reg <= run_reg + CW'(1);
    end
  end

  assign d_sync = filt_reg;
`else
  assign d_sync = sync_reg;
`endif

endmodule

// File: rtl/qdec_step_gen.sv
// Quadrature decoder: synchronised A/B/Z -> step/dir pulses, index load strobe,
// illegal-transition error pulse and sticky flag. Optional define: QDEC_FILTER_EN.
module qdec_step_gen
  import qdec_pkg::*;
  #(
    parameter int FILTER_LEN = 4
  )
  (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic z,
    input  logic idx_en,
    input  logic err_clr,
    output logic step,
    output logic dir,
    output logic load,
    output logic err,
    output logic err_sticky
  );

  // Synced inputs become valid on the third edge after reset release, later with the filter.
  localparam int INIT_WAIT = 2 + (FILTER_ON ? FILTER_LEN : 0);
  localparam int ICW       = $clog2(INIT_WAIT + 1);

  logic [2:0] raw_in;
  logic [2:0] syn;

  assign raw_in = {z, b, a};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      qdec_sync
`ifdef QDEC_FILTER_EN
        #(.FILTER_LEN(FILTER_LEN))
`endif
        u_sync (
          .clk    (clk),
          .rst    (rst),
          .d_async(raw_in[gi]),
          .d_sync (syn[gi])
        );
    end
  endgenerate

  qdec_state_t state_reg;
  logic [ICW-1:0] init_cnt_reg;
  logic [1:0]     prev_reg;
  logic           z_prev_reg;
  logic           step_reg;
  logic           dir_reg;
  logic           load_reg;
  logic           err_reg;
  logic           sticky_reg;

  logic [1:0] cur;
  qdec_dec_t  dec;
  logic       in_run;
  logic       illegal_now;

  assign cur         = {syn[0], syn[1]};
  assign dec         = qdec_decode(prev_reg, cur);
  assign in_run      = (state_reg == ST_RUN);
  assign illegal_now = in_run & dec.illegal;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= ST_INIT;
      init_cnt_reg <= '0;
      prev_reg     <= Q00;
      z_prev_reg   <= 1'b0;
      step_reg     <= 1'b0;
      dir_reg      <= DIR_UP;
      load_reg     <= 1'b0;
      err_reg      <= 1'b0;
      sticky_reg   <= 1'b0;
    end else begin
      step_reg   <= 1'b0;
      err_reg    <= 1'b0;
      load_reg   <= 1'b0;
      z_prev_reg <= syn[2];
      // Set beats clear when both happen in the same cycle.
      sticky_reg <= illegal_now | (sticky_reg & ~err_clr);
      case (state_reg)
        ST_INIT: begin
          if (init_cnt_reg == ICW'(INIT_WAIT)) begin
            prev_reg  <= cur;
            state_reg <= ST_RUN;
          end else begin
            init_cnt_reg <= init_cnt_reg + ICW'(1);
          end
        end
        ST_RUN: begin
          // prev follows cur even on illegal jumps so decoding resynchronises.
          prev_reg <= cur;
          step_reg <= dec.legal_step;
          err_reg  <= dec.illegal;
          if (dec.legal_step) begin
            dir_reg <= dec.dir;
          end
          load_reg <= idx_en & syn[2] & ~z_prev_reg;
        end
        default: begin
          state_reg <= ST_INIT;
        end
      endcase
    end
  end

  assign step       = step_reg;
  assign dir        = dir_reg;
  assign load       = load_reg;
  assign err        = err_reg;
  assign err_sticky = sticky_reg;

endmodule
